// File: rtl/arc4_phase_ctrl.sv
// ARC4 phase sequencer: runs init -> ksa -> prga over en/rdy handshakes and owns the S-memory port.
// Optional run-length counter on cycle_count when ARC4_CYCLE_COUNT_EN is defined.
module arc4_phase_ctrl #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 2048
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              rdy,
    output logic              done,
    output logic              err,
    output logic [1:0]        phase,
    output logic              init_en,
    output logic              ksa_en,
    output logic              prga_en,
    input  logic              init_rdy,
    input  logic              ksa_rdy,
    input  logic              prga_rdy,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [ADDR_W-1:0] ksa_addr,
    input  logic [ADDR_W-1:0] prga_addr,
    input  logic [DATA_W-1:0] init_wrdata,
    input  logic [DATA_W-1:0] ksa_wrdata,
    input  logic [DATA_W-1:0] prga_wrdata,
    input  logic              init_wren,
    input  logic              ksa_wren,
    input  logic              prga_wren,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wrdata,
    output logic              s_wren,
    output logic [31:0]       cycle_count
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT_START,
        S_INIT_WAIT,
        S_KSA_START,
        S_KSA_WAIT,
        S_PRGA_START,
        S_PRGA_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;

    state_t          state;
    state_t          state_next;
    logic [WD_W-1:0] wd;
    logic            wd_active;
    logic            timeout;
    logic            past_first;

    assign wd_active  = (state != S_IDLE) && (state != S_DONE) && (state != S_ERR);
    assign timeout    = (wd == WD_W'(TIMEOUT_CYCLES - 1));
    // The watchdog is zero only in the first cycle of a state, which masks stale rdy on WAIT entry.
    assign past_first = (wd != '0);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            wd    <= '0;
        end else begin
            state <= state_next;
            if (state_next != state || !wd_active)
                wd <= '0;
            else
                wd <= wd + 1'b1;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:       if (en) state_next = S_INIT_START;
            S_INIT_START: if (init_rdy) state_next = S_INIT_WAIT;
                          else if (timeout) state_next = S_ERR;
            S_INIT_WAIT:  if (past_first && init_rdy) state_next = S_KSA_START;
                          else if (timeout) state_next = S_ERR;
            S_KSA_START:  if (ksa_rdy) state_next = S_KSA_WAIT;
                          else if (timeout) state_next = S_ERR;
            S_KSA_WAIT:   if (past_first && ksa_rdy) state_next = S_PRGA_START;
                          else if (timeout) state_next = S_ERR;
            S_PRGA_START: if (prga_rdy) state_next = S_PRGA_WAIT;
                          else if (timeout) state_next = S_ERR;
            S_PRGA_WAIT:  if (past_first && prga_rdy) state_next = S_DONE;
                          else if (timeout) state_next = S_ERR;
            S_DONE:       state_next = S_IDLE;
            S_ERR:        if (en) state_next = S_INIT_START;
            default:      state_next = S_IDLE;
        endcase
    end

    always_comb begin
        rdy      = (state == S_IDLE) || (state == S_ERR);
        done     = (state == S_DONE);
        err      = (state == S_ERR);
        init_en  = (state == S_INIT_START) && init_rdy;
        ksa_en   = (state == S_KSA_START) && ksa_rdy;
        prga_en  = (state == S_PRGA_START) && prga_rdy;
        phase    = 2'd0;
        s_addr   = '0;
        s_wrdata = '0;
        s_wren   = 1'b0;
        case (state)
            S_INIT_START, S_INIT_WAIT: phase = 2'd1;
            S_KSA_START,  S_KSA_WAIT:  phase = 2'd2;
            S_PRGA_START, S_PRGA_WAIT: phase = 2'd3;
            default:                   phase = 2'd0;
        endcase
        // Ownership follows the phase, so a non-owner's write enable never reaches memory.
        case (phase)
            2'd1: begin s_addr = init_addr; s_wrdata = init_wrdata; s_wren = init_wren; end
            2'd2: begin s_addr = ksa_addr;  s_wrdata = ksa_wrdata;  s_wren = ksa_wren;  end
            2'd3: begin s_addr = prga_addr; s_wrdata = prga_wrdata; s_wren = prga_wren; end
            default: ;
        endcase
    end

`ifdef ARC4_CYCLE_COUNT_EN
    logic [31:0] run_cnt;
    logic [31:0] run_cnt_inc;

    assign run_cnt_inc = (run_cnt == 32'hFFFF_FFFF) ? run_cnt : run_cnt + 32'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cnt     <= '0;
            cycle_count <= '0;
        end else begin
            if ((state == S_IDLE || state == S_ERR) && state_next == S_INIT_START)
                run_cnt <= '0;
            else if (state != S_IDLE)
                run_cnt <= run_cnt_inc;
            // Latched value includes the final PRGA_WAIT cycle being counted this edge.
            if (state_next == S_DONE && state != S_DONE)
                cycle_count <= run_cnt_inc;
        end
    end
`else
    assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_arc4_phase_ctrl.sv
// Self-checking bench for arc4_phase_ctrl with stub engines of configurable rdy latency.
module tb_arc4_phase_ctrl;

    localparam int TO      = 16;
    localparam int MAX_CYC = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        rdy, done, err;
    logic [1:0]  phase;
    logic        init_en, ksa_en, prga_en;
    logic        init_rdy, ksa_rdy, prga_rdy;
    logic [7:0]  init_addr, ksa_addr, prga_addr;
    logic [7:0]  init_wrdata, ksa_wrdata, prga_wrdata;
    logic        init_wren, ksa_wren, prga_wren;
    logic [7:0]  s_addr, s_wrdata;
    logic        s_wren;
    logic [31:0] cycle_count;

    int vectors     = 0;
    int miscompares = 0;

    // Stub engines: rdy drops after an accepted en and returns lat[i] cycles later.
    int   eng_cnt[3] = '{0, 0, 0};
    int   lat[3]     = '{4, 4, 4};
    bit   hold[3]    = '{1'b0, 1'b0, 1'b0};
    logic [2:0] e_en, e_rdy;

    assign e_en     = {prga_en, ksa_en, init_en};
    assign init_rdy = (eng_cnt[0] == 0) && !hold[0];
    assign ksa_rdy  = (eng_cnt[1] == 0) && !hold[1];
    assign prga_rdy = (eng_cnt[2] == 0) && !hold[2];
    assign e_rdy    = {prga_rdy, ksa_rdy, init_rdy};

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (e_en[i] && e_rdy[i])
                eng_cnt[i] <= lat[i];
            else if (eng_cnt[i] > 0)
                eng_cnt[i] <= eng_cnt[i] - 1;
        end
    end

    always #5 clk = ~clk;

    arc4_phase_ctrl #(
        .ADDR_W(8),
        .DATA_W(8),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .rdy(rdy), .done(done), .err(err), .phase(phase),
        .init_en(init_en), .ksa_en(ksa_en), .prga_en(prga_en),
        .init_rdy(init_rdy), .ksa_rdy(ksa_rdy), .prga_rdy(prga_rdy),
        .init_addr(init_addr), .ksa_addr(ksa_addr), .prga_addr(prga_addr),
        .init_wrdata(init_wrdata), .ksa_wrdata(ksa_wrdata), .prga_wrdata(prga_wrdata),
        .init_wren(init_wren), .ksa_wren(ksa_wren), .prga_wren(prga_wren),
        .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren), .cycle_count(cycle_count)
    );

    // Observations of the most recent run, filled by do_run.
    int r_phase_sig, r_en_sig, r_done, r_nonidle, r_mux_err, r_en_viol, r_stall_bad;
    bit r_stall_hit, r_timeout;

    task automatic rand_bus(input bit force_wren);
        init_addr   = 8'($urandom); ksa_addr   = 8'($urandom); prga_addr   = 8'($urandom);
        init_wrdata = 8'($urandom); ksa_wrdata = 8'($urandom); prga_wrdata = 8'($urandom);
        init_wren = force_wren ? 1'b1 : 1'($urandom);
        ksa_wren  = force_wren ? 1'b1 : 1'($urandom);
        prga_wren = force_wren ? 1'b1 : 1'($urandom);
    endtask

    // Issues one start and records phase/en order, done pulses, run length and mux errors.
    task automatic do_run(input int stall, input bit noise);
        int         last_phase;
        logic [7:0] ea, ed;
        logic       ew;
        r_phase_sig = 0; r_en_sig = 0; r_done = 0; r_nonidle = 0;
        r_mux_err = 0; r_en_viol = 0; r_stall_bad = 0; r_stall_hit = 1'b0;
        r_timeout = 1'b1; last_phase = 0;
        en = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= MAX_CYC; k++) begin
            en = (noise && !rdy) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (stall > 0) hold[0] = (k <= stall);
            rand_bus(1'b0);
            #1;
            if (int'(phase) != last_phase) begin
                r_phase_sig = r_phase_sig * 10 + int'(phase);
                last_phase  = int'(phase);
            end
            if (init_en) begin r_en_sig = r_en_sig * 10 + 1; if (!init_rdy) r_en_viol++; end
            if (ksa_en)  begin r_en_sig = r_en_sig * 10 + 2; if (!ksa_rdy)  r_en_viol++; end
            if (prga_en) begin r_en_sig = r_en_sig * 10 + 3; if (!prga_rdy) r_en_viol++; end
            if (done) r_done++;
            if (phase != 2'd0) r_nonidle++;
            case (phase)
                2'd1:    {ea, ed, ew} = {init_addr, init_wrdata, init_wren};
                2'd2:    {ea, ed, ew} = {ksa_addr, ksa_wrdata, ksa_wren};
                2'd3:    {ea, ed, ew} = {prga_addr, prga_wrdata, prga_wren};
                default: {ea, ed, ew} = '0;
            endcase
            if ({s_addr, s_wrdata, s_wren} !== {ea, ed, ew}) r_mux_err++;
            if (stall > 0 && k <= stall && init_en) r_stall_bad++;
            if (stall > 0 && k == stall + 1) r_stall_hit = init_en;
            if (r_done > 0 && rdy) begin r_timeout = 1'b0; break; end
            @(negedge clk);
        end
        en = 1'b0;
        hold[0] = 1'b0;
    endtask

    function automatic logic [31:0] exp_cc(input int n);
`ifdef ARC4_CYCLE_COUNT_EN
        return 32'(n);
`else
        return 32'(n - n);
`endif
    endfunction

    task automatic test_reset();
        rst = 1'b1; en = 1'b0;
        init_addr = '0; ksa_addr = '0; prga_addr = '0;
        init_wrdata = '0; ksa_wrdata = '0; prga_wrdata = '0;
        init_wren = 1'b1; ksa_wren = 1'b1; prga_wren = 1'b1;
        #1;
        vectors++;
        if ({rdy, done, err, phase, init_en, ksa_en, prga_en} !== 8'b1000_0000) begin
            miscompares++;
            $display("FAIL reset_ctrl got rdy=%b done=%b err=%b phase=%0d en=%b%b%b want 1 0 0 0 000",
                     rdy, done, err, phase, init_en, ksa_en, prga_en);
        end
        vectors++;
        if ({s_addr, s_wrdata, s_wren} !== 17'd0 || cycle_count !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_mem got s_addr=%h s_wrdata=%h s_wren=%b cc=%0d want zeros",
                     s_addr, s_wrdata, s_wren, cycle_count);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_run();
        int exp_n;
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < 3; i++) lat[i] = $urandom_range(1, 8);
            exp_n = lat[0] + lat[1] + lat[2] + 6;
            do_run(0, it[0]);
            vectors++;
            if (r_timeout || r_phase_sig != 1230 || r_en_sig != 123 || r_done != 1) begin
                miscompares++;
                $display("FAIL full_run_seq it=%0d got phases=%0d ens=%0d done=%0d timeout=%b want 1230 123 1 0",
                         it, r_phase_sig, r_en_sig, r_done, r_timeout);
            end
            vectors++;
            if (r_nonidle != exp_n) begin
                miscompares++;
                $display("FAIL full_run_len it=%0d got %0d want %0d", it, r_nonidle, exp_n);
            end
            vectors++;
            if (r_mux_err != 0 || r_en_viol != 0) begin
                miscompares++;
                $display("FAIL full_run_mux it=%0d got mux_err=%0d en_viol=%0d want 0 0", it, r_mux_err, r_en_viol);
            end
            vectors++;
            if (cycle_count !== exp_cc(exp_n) || rdy !== 1'b1 || err !== 1'b0) begin
                miscompares++;
                $display("FAIL full_run_end it=%0d got cc=%0d rdy=%b err=%b want cc=%0d rdy=1 err=0",
                         it, cycle_count, rdy, err, exp_cc(exp_n));
            end
        end
    endtask

    task automatic test_back_to_back();
        int exp_n;
        lat = '{4, 4, 4};
        exp_n = 18;
        for (int r = 0; r < 2; r++) begin
            do_run(0, 1'b0);
            vectors++;
            if (r_timeout || r_phase_sig != 1230 || r_en_sig != 123 || r_done != 1 || r_nonidle != exp_n) begin
                miscompares++;
                $display("FAIL back_to_back r=%0d got phases=%0d ens=%0d done=%0d len=%0d want 1230 123 1 %0d",
                         r, r_phase_sig, r_en_sig, r_done, r_nonidle, exp_n);
            end
        end
    endtask

    task automatic test_mux_ksa();
        bit seen = 1'b0;
        lat = '{4, 4, 4};
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            #1;
            if (phase == 2'd2) seen = 1'b1;
            else @(negedge clk);
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL mux_ksa_reach got phase=%0d want 2 within budget", phase);
        end
        rand_bus(1'b0);
        init_wren = 1'b1; init_addr = 8'h11;
        ksa_wren  = 1'b1; ksa_addr  = 8'h22; ksa_wrdata = 8'h5A;
        #1;
        vectors++;
        if ({s_addr, s_wrdata, s_wren} !== {8'h22, 8'h5A, 1'b1}) begin
            miscompares++;
            $display("FAIL mux_ksa_owner got %h %h %b want 22 5a 1", s_addr, s_wrdata, s_wren);
        end
        ksa_wren = 1'b0;
        #1;
        vectors++;
        if (s_wren !== 1'b0) begin
            miscompares++;
            $display("FAIL mux_ksa_nowren got s_wren=%b want 0", s_wren);
        end
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            #1;
            if (rdy) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL mux_ksa_finish got rdy=%b want 1 within budget", rdy);
        end
    endtask

    task automatic test_watchdog();
        int          ksa_cycles = 0;
        logic [31:0] cc_before;
        bit          seen = 1'b0;
        lat = '{4, 4, 4};
        cc_before = cycle_count;
        hold[1] = 1'b1;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            rand_bus(1'b1);
            #1;
            if (phase == 2'd2) ksa_cycles++;
            if (err) seen = 1'b1;
            else @(negedge clk);
        end
        vectors++;
        if (!seen || ksa_cycles != TO) begin
            miscompares++;
            $display("FAIL wd_count got err=%b ksa_cycles=%0d want 1 %0d", err, ksa_cycles, TO);
        end
        vectors++;
        if (phase !== 2'd0 || rdy !== 1'b1 || s_wren !== 1'b0 || s_addr !== 8'h00) begin
            miscompares++;
            $display("FAIL wd_err_outs got phase=%0d rdy=%b s_wren=%b s_addr=%h want 0 1 0 00",
                     phase, rdy, s_wren, s_addr);
        end
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (err !== 1'b1 || cycle_count !== cc_before) begin
            miscompares++;
            $display("FAIL wd_sticky got err=%b cc=%0d want 1 %0d", err, cycle_count, cc_before);
        end
        hold[1] = 1'b0;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        #1;
        vectors++;
        if (phase !== 2'd1 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL wd_restart got phase=%0d err=%b want 1 0", phase, err);
        end
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL wd_recover got done=%b want 1 within budget", done);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_prga();
        bit seen = 1'b0;
        int dones = 0;
        lat = '{4, 4, 4};
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            #1;
            if (phase == 2'd3) seen = 1'b1;
            else @(negedge clk);
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL rst_prga_reach got phase=%0d want 3", phase);
        end
        rand_bus(1'b1);
        #1;
        rst = 1'b1;
        #1;
        vectors++;
        if ({rdy, done, err, phase, init_en, ksa_en, prga_en, s_wren} !== 9'b1000_00000 ||
            {s_addr, s_wrdata} !== 16'd0 || cycle_count !== 32'd0) begin
            miscompares++;
            $display("FAIL rst_prga_async got rdy=%b done=%b err=%b phase=%0d s=%h/%h/%b cc=%0d want reset values",
                     rdy, done, err, phase, s_addr, s_wrdata, s_wren, cycle_count);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            if (done || !rdy) dones++;
        end
        vectors++;
        if (dones != 0) begin
            miscompares++;
            $display("FAIL rst_prga_quiet got %0d cycles with done or !rdy want 0", dones);
        end
    endtask

    task automatic test_stalled_start();
        int exp_n;
        lat = '{4, 4, 4};
        exp_n = 18 + 5;
        hold[0] = 1'b1;
        do_run(5, 1'b1);
        vectors++;
        if (r_stall_bad != 0 || r_stall_hit != 1'b1) begin
            miscompares++;
            $display("FAIL stall_pulse got early_en=%0d en_at_release=%b want 0 1", r_stall_bad, r_stall_hit);
        end
        vectors++;
        if (r_timeout || r_phase_sig != 1230 || r_en_sig != 123 || r_done != 1 || r_nonidle != exp_n) begin
            miscompares++;
            $display("FAIL stall_run got phases=%0d ens=%0d done=%0d len=%0d want 1230 123 1 %0d",
                     r_phase_sig, r_en_sig, r_done, r_nonidle, exp_n);
        end
        vectors++;
        if (r_mux_err != 0 || r_en_viol != 0 || cycle_count !== exp_cc(exp_n)) begin
            miscompares++;
            $display("FAIL stall_misc got mux_err=%0d en_viol=%0d cc=%0d want 0 0 %0d",
                     r_mux_err, r_en_viol, cycle_count, exp_cc(exp_n));
        end
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_back_to_back();
        test_mux_ksa();
        test_watchdog();
        test_reset_mid_prga();
        test_stalled_start();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
